// File: rtl/serial_tx_pkg.sv
// Shared types for the serial transmit path: FSM state encoding and frame length.
// Optional parity bit is enabled with the SERIAL_TX_PARITY_EN macro.
`timescale 1ns/1ps
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Serial bit periods per frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_width);
`ifdef SERIAL_TX_PARITY_EN
        return data_width + 3;
`else
        return data_width + 2;
`endif
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while EN is high, TC marks the last cycle.
// Shared with the receiver side; the count clears whenever EN drops.
`timescale 1ns/1ps
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    output logic TC
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (!EN || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TC = EN && (cnt == LAST);

endmodule

// File: rtl/serial_tx_frame.sv
// Async-frame serial transmitter: start bit, data LSB-first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
`timescale 1ns/1ps
module serial_tx_frame
    import serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PARALLEL_LOAD,
    input  logic                  Tx_DATA,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  TX_OUT,
    output logic                  Tx_DONE,
    output logic [3:0]            BIT_IDX,
    output state_t                STATE
);

    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] frame_word;
    logic                  bit_tc;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_q;
`endif

    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_bit_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (state != IDLE),
        .TC    (bit_tc)
    );

    // A load in the same cycle as the start bypasses the holding register.
    assign frame_word = PARALLEL_LOAD ? DATA_IN : hold_q;
    assign STATE      = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            Tx_DONE  <= 1'b1;
            BIT_IDX  <= 4'd0;
            hold_q   <= '0;
            shift_q  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT  <= 1'b1;
                    Tx_DONE <= 1'b1;
                    BIT_IDX <= 4'd0;
                    if (PARALLEL_LOAD) hold_q <= DATA_IN;
                    if (Tx_DATA) begin
                        shift_q  <= frame_word;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^frame_word;
`endif
                        state    <= START;
                        TX_OUT   <= 1'b0;
                        Tx_DONE  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_tc) begin
                        state   <= DATA;
                        TX_OUT  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        BIT_IDX <= 4'd0;
                    end
                end
                DATA: begin
                    if (bit_tc) begin
                        if (BIT_IDX == LAST_IDX) begin
                            BIT_IDX <= 4'd0;
`ifdef SERIAL_TX_PARITY_EN
                            state   <= PARITY;
                            TX_OUT  <= parity_q;
`else
                            state   <= STOP;
                            TX_OUT  <= 1'b1;
`endif
                        end else begin
                            BIT_IDX <= BIT_IDX + 4'd1;
                            TX_OUT  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_tc) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_tc) begin
                        state   <= IDLE;
                        TX_OUT  <= 1'b1;
                        Tx_DONE <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    TX_OUT  <= 1'b1;
                    Tx_DONE <= 1'b1;
                    BIT_IDX <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Scoreboard bench for serial_tx_frame: stimulus queues expected frames, a monitor
// captures each frame off TX_OUT and compares it.
`timescale 1ns/1ps
module tb_serial_tx_frame;
    import serial_tx_pkg::*;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = DW + 3;
    // {stop, parity, d7..d0, start}
    localparam logic [NBITS-1:0] F_A5 = 11'b1_0_10100101_0;
    localparam logic [NBITS-1:0] F_3C = 11'b1_0_00111100_0;
    localparam logic [NBITS-1:0] F_5A = 11'b1_0_01011010_0;
    localparam logic [NBITS-1:0] F_07 = 11'b1_1_00000111_0;
    localparam logic [NBITS-1:0] F_81 = 11'b1_0_10000001_0;
    localparam logic [NBITS-1:0] F_00 = 11'b1_0_00000000_0;
`else
    localparam int NBITS = DW + 2;
    // {stop, d7..d0, start}
    localparam logic [NBITS-1:0] F_A5 = 10'b1_10100101_0;
    localparam logic [NBITS-1:0] F_3C = 10'b1_00111100_0;
    localparam logic [NBITS-1:0] F_5A = 10'b1_01011010_0;
    localparam logic [NBITS-1:0] F_07 = 10'b1_00000111_0;
    localparam logic [NBITS-1:0] F_81 = 10'b1_10000001_0;
    localparam logic [NBITS-1:0] F_00 = 10'b1_00000000_0;
`endif
    localparam int FRAME_CYCLES = NBITS * CPB;
    localparam int MON_LIMIT    = FRAME_CYCLES + 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          PARALLEL_LOAD = 1'b0;
    logic          Tx_DATA = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic          TX_OUT;
    logic          Tx_DONE;
    logic [3:0]    BIT_IDX;
    state_t        STATE;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int last_gap = 0;
    int idle_run = 0;
    logic [NBITS-1:0] exp_q[$];

    serial_tx_frame #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .CNT_WIDTH    (16)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PARALLEL_LOAD (PARALLEL_LOAD),
        .Tx_DATA       (Tx_DATA),
        .DATA_IN       (DATA_IN),
        .TX_OUT        (TX_OUT),
        .Tx_DONE       (Tx_DONE),
        .BIT_IDX       (BIT_IDX),
        .STATE         (STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (Tx_DONE && k < 20) begin tick(); k++; end
        while (!Tx_DONE && k < 200) begin tick(); k++; end
        if (k >= 200) check(name, 32'(Tx_DONE), 32'd1);
    endtask

    task automatic wait_frames(input string name, input int target);
        int k;
        k = 0;
        while (frames_seen < target && k < 300) begin tick(); k++; end
        if (k >= 300) check(name, frames_seen, target);
    endtask

    task automatic load(input logic [DW-1:0] d);
        DATA_IN = d;
        PARALLEL_LOAD = 1'b1;
        tick();
        PARALLEL_LOAD = 1'b0;
        DATA_IN = '0;
    endtask

    task automatic start(input logic [NBITS-1:0] exp_frame);
        exp_q.push_back(exp_frame);
        Tx_DATA = 1'b1;
        tick();
        Tx_DATA = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int n;
        int b;
        logic [NBITS-1:0] bits;
        logic [NBITS-1:0] exp_f;
        logic stable;
        logic idx_ok;
        logic [3:0] exp_idx;
        forever begin
            @(negedge CLK);
            if (RESET || Tx_DONE) begin
                idle_run++;
            end else begin
                last_gap = idle_run;
                frames_seen++;
                n = 0;
                bits = '0;
                stable = 1'b1;
                idx_ok = 1'b1;
                while (!RESET && !Tx_DONE && n < MON_LIMIT) begin
                    b = n / CPB;
                    if (b < NBITS) begin
                        if (n % CPB == 0) bits[b] = TX_OUT;
                        else if (TX_OUT !== bits[b]) stable = 1'b0;
                        exp_idx = (b >= 1 && b <= DW) ? 4'(b - 1) : 4'd0;
                        if (BIT_IDX !== exp_idx) idx_ok = 1'b0;
                    end
                    n++;
                    @(negedge CLK);
                end
                idle_run = 1;
                if (RESET) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else if (n >= MON_LIMIT) begin
                    check("frame_timeout", n, FRAME_CYCLES);
                    idle_run = 0;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame %b, required no frame", bits);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("frame_bits", 32'(bits), 32'(exp_f));
                    check("frame_len", n, FRAME_CYCLES);
                    check("bit_stable", 32'(stable), 32'd1);
                    check("bit_idx_seq", 32'(idx_ok), 32'd1);
                    check("idle_tx_out", 32'(TX_OUT), 32'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int base;
        int k;

        RESET = 1'b1;
        repeat (3) tick();
        check("rst_tx_out", 32'(TX_OUT), 32'd1);
        check("rst_tx_done", 32'(Tx_DONE), 32'd1);
        check("rst_bit_idx", 32'(BIT_IDX), 32'd0);
        check("rst_state", 32'(STATE), 32'(IDLE));
        RESET = 1'b0;
        tick();

        // basic frame from the holding register
        load(8'hA5);
        start(F_A5);
        check("busy_after_start", 32'(Tx_DONE), 32'd0);
        wait_done("basic_done");
        tick();

        // load and start together, then resend from the holding register
        DATA_IN = 8'h3C;
        PARALLEL_LOAD = 1'b1;
        start(F_3C);
        PARALLEL_LOAD = 1'b0;
        DATA_IN = '0;
        wait_done("bypass_done");
        tick();
        start(F_3C);
        wait_done("hold_3c_done");
        tick();

        // requests during a frame are ignored
        load(8'hA5);
        start(F_A5);
        repeat (12) tick();
        DATA_IN = 8'hFF;
        PARALLEL_LOAD = 1'b1;
        Tx_DATA = 1'b1;
        tick();
        PARALLEL_LOAD = 1'b0;
        Tx_DATA = 1'b0;
        DATA_IN = '0;
        wait_done("busy_done");
        base = frames_seen;
        repeat (15) tick();
        check("no_queued_frame", frames_seen, base);
        check("idle_after_busy", 32'(Tx_DONE), 32'd1);
        start(F_A5);
        wait_done("hold_a5_done");
        tick();

        // back-to-back with Tx_DATA held high
        load(8'h5A);
        base = frames_seen;
        exp_q.push_back(F_5A);
        exp_q.push_back(F_5A);
        exp_q.push_back(F_5A);
        Tx_DATA = 1'b1;
        wait_frames("b2b_second", base + 2);
        check("b2b_gap_1", last_gap, 1);
        wait_frames("b2b_third", base + 3);
        check("b2b_gap_2", last_gap, 1);
        Tx_DATA = 1'b0;
        wait_done("b2b_done");
        tick();

        // odd population: parity bit set when enabled
        load(8'h07);
        start(F_07);
        wait_done("par07_done");
        tick();

        // asynchronous reset in the middle of the data bits
        load(8'h81);
        start(F_81);
        k = 0;
        while (BIT_IDX != 4'd2 && k < 100) begin tick(); k++; end
        check("pre_rst_tx_out", 32'(TX_OUT), 32'd0);
        check("pre_rst_busy", 32'(Tx_DONE), 32'd0);
        #1;
        RESET = 1'b1;
        #1;
        check("async_rst_tx_out", 32'(TX_OUT), 32'd1);
        check("async_rst_tx_done", 32'(Tx_DONE), 32'd1);
        check("async_rst_bit_idx", 32'(BIT_IDX), 32'd0);
        repeat (3) tick();
        RESET = 1'b0;
        base = frames_seen;
        repeat (20) tick();
        check("idle_after_reset", frames_seen, base);
        check("done_after_reset", 32'(Tx_DONE), 32'd1);
        check("state_after_reset", 32'(STATE), 32'(IDLE));

        // holding register cleared by reset
        start(F_00);
        wait_done("hold_zero_done");
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
